// File: rtl/fir_pkg.sv
// Shared constants, FSM state encoding and output saturation for the FIR tap sequencer.
package fir_pkg;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int PW = DW + CW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (DW - 1));

  function automatic logic signed [DW-1:0] sat_dw(input logic signed [63:0] r);
    if (r > SAT_MAX) begin
      return DW'(SAT_MAX);
    end else if (r < SAT_MIN) begin
      return DW'(SAT_MIN);
    end
    return DW'(r);
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// NTAPS-deep circular sample buffer: one write port, two combinational read ports
// addressed as offsets back from the newest sample (offset 0 = newest).
module fir_delay_line #(
  parameter int NTAPS = 32,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic signed [DW-1:0]     wdata,
  input  logic [$clog2(NTAPS)-1:0] rd_off0,
  input  logic [$clog2(NTAPS)-1:0] rd_off1,
  output logic signed [DW-1:0]     rd_data0,
  output logic signed [DW-1:0]     rd_data1
);

  localparam int AW = $clog2(NTAPS);

  logic signed [DW-1:0] mem_q [NTAPS];
  logic signed [DW-1:0] mem_d [NTAPS];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        newest;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (we) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Power-of-two depth makes the modulo wrap a plain AW-bit subtraction.
  assign newest   = wr_ptr_q - AW'(1);
  assign rd_data0 = mem_q[newest - rd_off0];
  assign rd_data1 = mem_q[newest - rd_off1];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sample-rate FIR sequencer feeding an external 2-cycle dual-MAC (p = a0*b0 + a1*b1).
// Define FIR_ROUND_EN for round-half-up before saturation; default is truncation.
module fir_tap_sequencer #(
  parameter int NTAPS   = 32,
  parameter int DW      = fir_pkg::DW,
  parameter int CW      = fir_pkg::CW,
  parameter int PW      = fir_pkg::PW,
  parameter int MUL_LAT = 2,
  parameter int SHIFT   = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DW-1:0]     s_data,
  input  logic                     coef_we,
  input  logic [$clog2(NTAPS)-1:0] coef_addr,
  input  logic signed [CW-1:0]     coef_wdata,
  output logic signed [DW-1:0]     ma_a0,
  output logic signed [CW-1:0]     ma_b0,
  output logic signed [DW-1:0]     ma_a1,
  output logic signed [CW-1:0]     ma_b1,
  output logic                     ma_addsub,
  input  logic signed [PW-1:0]     ma_p,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [DW-1:0]     m_data,
  output logic                     busy
);
  import fir_pkg::*;

  localparam int AW    = $clog2(NTAPS);
  localparam int NPAIR = NTAPS / 2;
  localparam int PCW   = $clog2(NPAIR);
  localparam int DCW   = $clog2(MUL_LAT + 1) + 1;
  localparam int ACC_W = PW + $clog2(NTAPS / 2);

  // Handshakes: a transfer happens on a rising edge where valid && ready; s_ready is
  // high only in IDLE, and m_valid/m_data hold steady in OUT until m_ready is seen.
  state_e               state_q, state_d;
  logic [PCW-1:0]       pair_q, pair_d;
  logic [DCW-1:0]       drain_q, drain_d;
  logic [MUL_LAT-1:0]   tag_q, tag_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [DW-1:0] m_data_q, m_data_d;
  logic signed [CW-1:0] coef_q [NTAPS];
  logic signed [CW-1:0] coef_d [NTAPS];

  logic                 accept;
  logic                 issue;
  logic signed [DW-1:0] x0, x1;
  logic signed [63:0]   acc_ext, res_r;

  assign accept = (state_q == IDLE) && s_valid;
  assign issue  = (state_q == RUN);

  fir_delay_line #(
    .NTAPS (NTAPS),
    .DW    (DW)
  ) u_delay_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (accept),
    .wdata    (s_data),
    .rd_off0  ({pair_q, 1'b0}),
    .rd_off1  ({pair_q, 1'b1}),
    .rd_data0 (x0),
    .rd_data1 (x1)
  );

  always_comb begin
    acc_ext = 64'(acc_q);
`ifdef FIR_ROUND_EN
    res_r = (acc_ext + (64'sd1 <<< (SHIFT - 1))) >>> SHIFT;
`else
    res_r = acc_ext >>> SHIFT;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pair_q   <= '0;
      drain_q  <= '0;
      tag_q    <= '0;
      acc_q    <= '0;
      m_data_q <= '0;
      for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pair_q   <= pair_d;
      drain_q  <= drain_d;
      tag_q    <= tag_d;
      acc_q    <= acc_d;
      m_data_q <= m_data_d;
      coef_q   <= coef_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pair_d   = pair_q;
    drain_d  = drain_q;
    m_data_d = m_data_q;
    coef_d   = coef_q;
    acc_d    = acc_q;
    // Each issued pair is tagged; only a tag leaving the pipe admits ma_p into acc.
    tag_d    = MUL_LAT'({tag_q, issue});
    if (tag_q[MUL_LAT-1]) begin
      acc_d = acc_q + ACC_W'(ma_p);
    end
    if (coef_we && (state_q == IDLE)) begin
      coef_d[coef_addr] = coef_wdata;
    end
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d = RUN;
          pair_d  = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        pair_d = pair_q + PCW'(1);
        if (pair_q == PCW'(NPAIR - 1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        // Covers the multiplier latency plus the cycle that folds in the last product.
        drain_d = drain_q + DCW'(1);
        if (drain_q == DCW'(MUL_LAT)) begin
          state_d  = OUT;
          m_data_d = sat_dw(res_r);
        end
      end
      OUT: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = (state_q == IDLE);
    busy      = (state_q != IDLE);
    m_valid   = (state_q == OUT);
    m_data    = m_data_q;
    ma_addsub = 1'b0;
    ma_a0     = '0;
    ma_b0     = '0;
    ma_a1     = '0;
    ma_b1     = '0;
    if (state_q == RUN) begin
      ma_a0 = x0;
      ma_b0 = coef_q[{pair_q, 1'b0}];
      ma_a1 = x1;
      ma_b1 = coef_q[{pair_q, 1'b1}];
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer with a behavioural dual-MAC and a
// direct-form FIR reference model (honours FIR_ROUND_EN).
module tb_fir_tap_sequencer;

  localparam int NT = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic        coef_we;
  logic [4:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic [15:0] ma_a0, ma_b0, ma_a1, ma_b1;
  logic        ma_addsub;
  logic [32:0] ma_p;
  logic        m_valid, m_ready;
  logic [15:0] m_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  longint      h_m [NT];
  longint      x_m [NT];
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  fir_tap_sequencer #(.NTAPS(NT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .ma_a0      (ma_a0),
    .ma_b0      (ma_b0),
    .ma_a1      (ma_a1),
    .ma_b1      (ma_b1),
    .ma_addsub  (ma_addsub),
    .ma_p       (ma_p),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
  );

  // Dual-MAC with two register stages.
  longint      ma_sum;
  logic [32:0] ma_s1;
  always_comb ma_sum = longint'($signed(ma_a0)) * longint'($signed(ma_b0))
                     + longint'($signed(ma_a1)) * longint'($signed(ma_b1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_s1 <= '0;
      ma_p  <= '0;
    end else begin
      ma_s1 <= ma_sum[32:0];
      ma_p  <= ma_s1;
    end
  end

  function automatic logic [15:0] model_out();
    longint acc = 0;
    for (int k = 0; k < NT; k++) acc += h_m[k] * x_m[k];
`ifdef FIR_ROUND_EN
    acc += 64'sd16384;
`endif
    acc = acc >>> 15;
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    return acc[15:0];
  endfunction

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic write_coef(input int k, input logic [15:0] v);
    @(negedge clk);
    coef_we    = 1'b1;
    coef_addr  = 5'(k);
    coef_wdata = v;
    @(posedge clk);
    h_m[k] = longint'($signed(v));
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic send(input logic [15:0] x, input string tag, input int stall,
                      output logic [15:0] obs);
    int guard = 0;
    int lat   = 0;
    logic [15:0] hold;
    logic [15:0] expv;
    @(negedge clk);
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_accept_timeout"}, longint'(guard < 200), 1);
    m_ready = (stall == 0);
    s_valid = 1'b1;
    s_data  = x;
    @(posedge clk);
    for (int k = NT - 1; k > 0; k--) x_m[k] = x_m[k-1];
    x_m[0] = longint'($signed(x));
    exp_q.push_back(model_out());
    @(negedge clk);
    s_valid = 1'b0;
    while (!m_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 19);
    expv = exp_q.pop_front();
    hold = m_data;
    for (int i = 0; i < stall; i++) begin
      coef_we    = 1'b1;
      coef_addr  = 5'(i);
      coef_wdata = 16'(16'h1234 + i);
      s_valid    = 1'b1;
      s_data     = 16'($urandom);
      @(negedge clk);
      chk({tag, "_stall_valid"}, m_valid, 1);
      chk({tag, "_stall_data"}, m_data, hold);
      chk({tag, "_stall_sready"}, s_ready, 0);
    end
    coef_we = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk({tag, "_data"}, m_data, expv);
    obs = m_data;
    @(posedge clk);
  endtask

  initial begin
    logic [15:0] obs;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; coef_we = 1'b0;
    coef_addr = '0; coef_wdata = '0; m_ready = 1'b1;
    for (int k = 0; k < NT; k++) begin h_m[k] = 0; x_m[k] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ma", {ma_a0, ma_b0, ma_a1, ma_b1}, 0);
    chk("rst_addsub", ma_addsub, 0);
    rst_n = 1'b1;

    // Impulse through a ramp of coefficients
    for (int k = 0; k < NT; k++) write_coef(k, 16'(k * 256));
    send(16'h7fff, "impulse0", 0, obs);
    for (int j = 1; j < NT; j++) send(16'h0000, $sformatf("impulse%0d", j), 0, obs);

    // Pure gain on tap 0
    for (int k = 0; k < NT; k++) write_coef(k, (k == 0) ? 16'h4000 : 16'h0000);
    send(16'h2000, "gain", 0, obs);
    chk("gain_value", obs, 16'h1000);

    // Rounding of a half-LSB result
    write_coef(0, 16'h0001);
    send(16'h4000, "round", 0, obs);
`ifdef FIR_ROUND_EN
    chk("round_value", obs, 16'h0001);
`else
    chk("round_value", obs, 16'h0000);
`endif

    // Saturation in both directions
    for (int k = 0; k < NT; k++) write_coef(k, 16'h7fff);
    for (int j = 0; j < NT; j++) send(16'h7fff, "sat_pos", 0, obs);
    chk("sat_pos_last", obs, 16'h7fff);
    for (int j = 0; j < NT; j++) send(16'h8000, "sat_neg", 0, obs);
    chk("sat_neg_last", obs, 16'h8000);

    // Random coefficients and samples, with one backpressure episode
    for (int k = 0; k < NT; k++) write_coef(k, 16'($urandom_range(0, 16'hffff)));
    for (int j = 0; j < 16; j++)
      send(16'($urandom), "rand", (j == 5) ? 5 : 0, obs);

    // Asynchronous reset five cycles into RUN
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 16'h5a5a;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_s_ready", s_ready, 1);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ma", {ma_a0, ma_b0, ma_a1, ma_b1}, 0);
    for (int k = 0; k < NT; k++) begin h_m[k] = 0; x_m[k] = 0; end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NT; k++) write_coef(k, 16'($urandom_range(0, 16'hffff)));
    for (int j = 0; j < 4; j++) send(16'($urandom), "post_rst", 0, obs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
